// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between a pipeline and a word-wide data memory
//
// Purpose: accepts one byte/half/word load or store at a time, checks it for
// alignment, range and size errors, drives a registered word-wide memory port
// (sub-word stores done as read-modify-write) and returns a one-cycle response.
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   req_valid         : request strobe, sampled only while busy=0
//   req_write         : 1 = store, 0 = load
//   req_size [1:0]    : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : zero-extend sub-word loads when 1
//   req_addr [31:0]   : byte address
//   req_wdata [31:0]  : store data, right-aligned for byte/half
//   busy              : high whenever not idle
//   resp_valid        : one-cycle completion pulse
//   resp_err          : error flag qualifying resp_valid
//   resp_rdata [31:0] : extended load data (0 for stores/errors), held until next response
//   mem_read/mem_write: registered memory strobes
//   mem_address       : registered word index
//   mem_write_data    : registered store word
//   mem_read_data     : memory data, valid the cycle after mem_read
module mem_access_unit #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RMW_RD, S_RMW_WAIT, S_RMW_WR, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        w_accept;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_req_err;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_misalign  = ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                       ((req_size == 2'b01) && req_addr[0]);
  // Any address bit above the memory's byte range makes the request out of range.
  assign w_range_err = (req_addr >> (ADDR_BITS + 2)) != 32'd0;
  assign w_req_err   = (req_size == 2'b11) || w_misalign || w_range_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err)               w_next = S_DONE;
          else if (!req_write)         w_next = S_RD;
          else if (req_size == 2'b10)  w_next = S_WR;
          else                         w_next = S_RMW_RD;
        end
      end
      S_RD:       w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_DONE;
      S_WR:       w_next = S_DONE;
      S_RMW_RD:   w_next = S_RMW_WAIT;
      S_RMW_WAIT: w_next = S_RMW_WR;
      S_RMW_WR:   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy       = (r_state != S_IDLE);
    resp_valid = (r_state == S_DONE);
  end

  // Lane extraction of the returned word for loads
  always_comb begin
    w_byte = mem_read_data[7:0];
    case (r_lane)
      2'd0: w_byte = mem_read_data[7:0];
      2'd1: w_byte = mem_read_data[15:8];
      2'd2: w_byte = mem_read_data[23:16];
      2'd3: w_byte = mem_read_data[31:24];
      default: w_byte = mem_read_data[7:0];
    endcase
    w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  end

  always_comb begin
    w_load_ext = mem_read_data;
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = mem_read_data;
    endcase
  end

  // Sub-word store merge: only the addressed lanes take new data.
  always_comb begin
    w_merged = mem_read_data;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = mem_read_data;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  // Registered datapath and memory strobes. Strobes are derived from the next
  // state so each is high for exactly the one cycle spent in RD/RMW_RD or WR/RMW_WR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_size           <= 2'b00;
      r_unsigned       <= 1'b0;
      r_lane           <= 2'b00;
      r_wdata          <= 16'd0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= 32'd0;
      r_mem_write_data <= 32'd0;
      r_resp_err       <= 1'b0;
      r_resp_rdata     <= 32'd0;
    end else begin
      r_mem_read  <= (w_next == S_RD) || (w_next == S_RMW_RD);
      r_mem_write <= (w_next == S_WR) || (w_next == S_RMW_WR);

      if (w_accept) begin
        r_size        <= req_size;
        r_unsigned    <= req_unsigned;
        r_lane        <= req_addr[1:0];
        r_wdata       <= req_wdata[15:0];
        r_mem_address <= {{(32 - ADDR_BITS){1'b0}}, req_addr[ADDR_BITS+1:2]};
        if (!w_req_err && req_write && (req_size == 2'b10)) begin
          r_mem_write_data <= req_wdata;
        end
      end

      if (r_state == S_RMW_WAIT) begin
        r_mem_write_data <= w_merged;
      end

      if (w_next == S_DONE) begin
        // Only the IDLE->DONE path is an error; only loads return data.
        r_resp_err   <= (r_state == S_IDLE);
        r_resp_rdata <= (r_state == S_RD_WAIT) ? w_load_ext : 32'd0;
      end
    end
  end

  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .busy           (busy),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: no reset, registered read data.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed view of a 1 KiB memory, plain arithmetic.
  function automatic void model(input bit wr, input bit [1:0] size, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                output bit err, output bit [31:0] rdata, output int lat,
                                output int n_rd, output int n_wr);
    int unsigned idx;
    int unsigned sh;
    bit [31:0] old;
    bit [31:0] mask;
    bit [31:0] val;
    idx   = addr[9:2];
    sh    = (addr % 4) * 8;
    err   = (size == 3) || (size == 2 && addr % 4 != 0) || (size == 1 && addr % 2 != 0) ||
            (addr >= 32'd1024);
    rdata = 0;
    n_rd  = 0;
    n_wr  = 0;
    lat   = 1;
    if (err) return;
    old = ref_mem[idx];
    if (!wr) begin
      n_rd = 1;
      lat  = 3;
      if (size == 0) begin
        val = (old >> sh) & 32'hFF;
        if (!uns && val >= 128) val = val - 32'd256;
      end else if (size == 1) begin
        val = (old >> sh) & 32'hFFFF;
        if (!uns && val >= 32768) val = val - 32'd65536;
      end else begin
        val = old;
      end
      rdata = val;
    end else if (size == 2) begin
      n_wr = 1;
      lat  = 2;
      ref_mem[idx] = wdata;
    end else begin
      n_rd = 1;
      n_wr = 1;
      lat  = 4;
      mask = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (old & ~mask) | ((wdata << sh) & mask);
    end
  endfunction

  // Issue one request from an idle negedge and check the whole transaction.
  task automatic run_req(input bit wr, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, input string tag);
    bit        e;
    bit [31:0] rd;
    int        lat, nrd, nwr;
    int        seen_rd, seen_wr, got;
    bit [31:0] exp_addr;
    int unsigned idx;
    seen_rd  = 0;
    seen_wr  = 0;
    got      = 0;
    exp_addr = {24'd0, addr[9:2]};
    idx      = addr[9:2];
    model(wr, size, uns, addr, wdata, e, rd, lat, nrd, nwr);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && got == 0; c++) begin
      check({tag, " strobe_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_read) begin
        seen_rd++;
        check({tag, " rd_addr"}, mem_address, exp_addr);
      end
      if (mem_write) begin
        seen_wr++;
        check({tag, " wr_addr"}, mem_address, exp_addr);
      end
      if (resp_valid) begin
        got = 1;
        check({tag, " latency"}, c, lat);
        check({tag, " err"}, {31'd0, resp_err}, {31'd0, e});
        check({tag, " rdata"}, resp_rdata, rd);
      end else begin
        @(negedge clk);
      end
    end
    if (got == 0) check({tag, " resp_timeout"}, 32'd0, 32'd1);
    check({tag, " n_read"}, seen_rd, nrd);
    check({tag, " n_write"}, seen_wr, nwr);
    @(negedge clk);
    check({tag, " pulse_once"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " rdata_hold"}, resp_rdata, rd);
    check({tag, " mem_word"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    ref_mem[5] = 32'h8899AABB;
    mem[5]     = 32'h8899AABB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst mem_write_data", mem_write_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed loads, extension, RMW store and errors
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "ld_word");
    run_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, "ld_sbyte");
    check("ld_sbyte const", resp_rdata, 32'hFFFFFF88);
    run_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, "ld_uhalf");
    check("ld_uhalf const", resp_rdata, 32'h0000AABB);
    run_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h12345677, "st_byte");
    check("st_byte const", mem[5], 32'h889977BB);
    run_req(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, "err_ld_mis");
    run_req(1'b1, 2'b01, 1'b0, 32'h400, 32'hFFFF, "err_st_range");
    check("err_st_range mem5", mem[5], 32'h889977BB);

    // Back-to-back: req_valid held; one load every 4 cycles
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h14;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b resp_valid", {31'd0, resp_valid}, {31'd0, (c % 4) == 3});
      check("b2b mem_read", {31'd0, mem_read}, {31'd0, (c % 4) == 1});
      check("b2b busy", {31'd0, busy}, {31'd0, (c % 4) != 0});
      check("b2b strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (resp_valid) check("b2b rdata", resp_rdata, ref_mem[5]);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b idle_after", {31'd0, busy}, 32'd0);

    // Reset during RMW_WAIT: abort, no write, no response
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h15;
    req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_rmw busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_rmw busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("rst_rmw no_write", {31'd0, mem_write}, 32'd0);
      check("rst_rmw no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("rst_rmw mem5", mem[5], ref_mem[5]);

    // Reset while a word-store strobe is out: the write still lands
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_wr strobe", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[8] = 32'hCAFEF00D;
    check("rst_wr no_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_wr busy", {31'd0, busy}, 32'd0);
    check("rst_wr committed", mem[8], 32'hCAFEF00D);
    @(negedge clk);
    check("rst_wr no_resp2", {31'd0, resp_valid}, 32'd0);

    // Reset beats req_valid at the same edge
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h14;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    check("rst_prio busy", {31'd0, busy}, 32'd0);
    check("rst_prio no_read", {31'd0, mem_read}, 32'd0);
    @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit [31:0] a;
      bit [1:0]  s;
      a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
      s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_req(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: word-index width, giving a 256-word data memory.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: pipeline memory request, sampled only when busy=0.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port req_unsigned, input, 1: zero-extend loads when 1; ignored for stores.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned for byte and half stores.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_err, output, 1: qualifies resp_valid; misaligned, out-of-range or illegal request.
REQ-013 SHALL have port resp_rdata, output, 32: extended load result; 0 for stores and errors.
REQ-014 SHALL have ports mem_read and mem_write, output, 1 each: memory strobes, registered.
REQ-015 SHALL have port mem_address, output, 32: word index {0, byte_addr[ADDR_BITS+1:2]}, registered.
REQ-016 SHALL have port mem_write_data, output, 32: registered.
REQ-017 SHALL have port mem_read_data, input, 32: memory returns it registered, valid in the cycle after mem_read is high.

Function
REQ-018 SHALL use states IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, DONE.
REQ-019 SHALL accept a request at an edge where state=IDLE and req_valid=1; req_valid while busy is ignored and the pipeline holds.
REQ-020 SHALL flag an error for: req_size=11; word access with addr[1:0]≠0; half access with addr[0]=1; addr[31:ADDR_BITS+2]≠0.
REQ-021 SHALL, for an erroneous request, assert no strobe, go to DONE, and return resp_err=1 with resp_rdata=0.
REQ-022 SHALL sequence a load as IDLE→RD (mem_read=1)→RD_WAIT (capture and extend mem_read_data)→DONE.
REQ-023 SHALL sequence a word store as IDLE→WR (mem_write=1, mem_write_data=req_wdata)→DONE.
REQ-024 SHALL sequence a byte or half store as IDLE→RMW_RD (mem_read=1)→RMW_WAIT (register merged word)→RMW_WR (mem_write=1)→DONE.
REQ-025 SHALL merge a sub-word store by replacing only the addressed lanes of the old word, leaving the other lanes unchanged.
REQ-026 SHALL use little-endian lanes: byte k=addr[1:0] occupies bits [8k+7:8k]; a half at addr[1]=h occupies bits [16h+15:16h].
REQ-027 SHALL sign- or zero-extend loaded bytes and halves per req_unsigned; a word load returns the word unchanged.
REQ-028 SHALL pulse resp_valid high for exactly the one cycle in DONE, then return to IDLE.
REQ-029 SHALL give latencies, counted from the accept edge to the resp_valid cycle: load 3, word store 2, sub-word store 4, error 1.
REQ-030 SHALL keep mem_read and mem_write never high together, and each high for exactly one cycle per access.
REQ-031 SHALL hold resp_rdata until the next DONE.

Reset
REQ-032 SHALL, with reset high at an edge, force IDLE, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0 and mem_write_data=0.
REQ-033 SHALL abort any transaction when reset hits mid-operation, with no response issued.
REQ-034 SHALL NOT suppress a memory write that is already in progress: a write strobe present during the cycle whose ending edge samples reset still commits, because the memory has no reset.
REQ-035 SHALL take priority of reset over req_valid at the same edge.

Verification
REQ-036 SHALL test load word: mem[5]=0x8899AABB, load word at address 0x14 -> mem_read one cycle, mem_address=5, resp_valid 3 cycles after accept, resp_rdata=0x8899AABB, resp_err=0.
REQ-037 SHALL test sign and zero extension: same word, signed byte load at 0x17 -> 0xFFFFFF88; unsigned half load at 0x14 -> 0x0000AABB.
REQ-038 SHALL test byte store read-modify-write: mem[5]=0x8899AABB, byte store 0x12345677 at 0x15 -> single write of 0x889977BB, resp_valid 4 cycles after accept.
REQ-039 SHALL test errors: word load at 0x16, and half store at 0x400 with ADDR_BITS=8 -> resp_valid+resp_err 1 cycle after accept, no strobe, memory unchanged.
REQ-040 SHALL test back-to-back requests: req_valid held continuously -> second request accepted only at an IDLE edge; no overlapping strobes.
REQ-041 SHALL test reset mid-operation: reset during RMW_WAIT -> no mem_write, no resp_valid, IDLE next cycle, memory unchanged.
